// File: rtl/pause_pkg.sv
// Shared types and helpers for the pause/dim controller.
package pause_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ENTER  = 2'd1,
        PAUSED = 2'd2,
        EXIT   = 2'd3
    } pause_state_t;

    localparam int SETTLE_W = 4;
    localparam int SEC_W    = 8;

    function automatic int cycles_per_sec(input int mhz);
        return mhz * 1_000_000;
    endfunction

endpackage

// File: rtl/pause_sec_timer.sv
// Prescaler plus saturating seconds counter; clr_i zeroes both in the same cycle.
// sec_reached_o is high while the count sits at SECS (registered, no extra latency).
module pause_sec_timer
    import pause_pkg::*;
#(
    parameter int CYC  = 40_000_000,
    parameter int SECS = 10
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    output logic sec_reached_o
);

    localparam int PW = (CYC > 1) ? $clog2(CYC) : 1;

    logic [PW-1:0]    presc_q, presc_d;
    logic [SEC_W-1:0] sec_q, sec_d;

    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        if (clr_i) begin
            presc_d = '0;
            sec_d   = '0;
        end else if (presc_q == PW'(CYC - 1)) begin
            presc_d = '0;
            if (sec_q != SEC_W'(SECS)) begin
                sec_d = sec_q + 1'b1;
            end
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            presc_q <= '0;
            sec_q   <= '0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
        end
    end

    assign sec_reached_o = (sec_q == SEC_W'(SECS));

endmodule

// File: rtl/pause_ctrl_multi.sv
// Merges button/OSD/subsystem pause requests into pause_cpu, acks requesters once halted, dims video after a long pause.
// Video has 1-cycle latency; PAUSE_FRAME_ALIGN_EN makes ENTER/EXIT wait for a vblank rising edge.
module pause_ctrl_multi
    import pause_pkg::*;
#(
    parameter int RW          = 3,
    parameter int GW          = 3,
    parameter int BW          = 3,
    parameter int CLKSPEED    = 40,
    parameter int DIM_SECONDS = 10,
    parameter int NUM_REQ     = 2,
    parameter int ACK_PAD     = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  user_button,
    input  logic                  osd_status,
    input  logic [1:0]            options,
    input  logic [NUM_REQ-1:0]    pause_req,
    output logic [NUM_REQ-1:0]    pause_ack,
    input  logic                  vblank,
    input  logic [RW-1:0]         r,
    input  logic [GW-1:0]         g,
    input  logic [BW-1:0]         b,
    output logic [RW+GW+BW-1:0]   rgb_out,
    output logic                  pause_cpu,
    output logic                  dimmed
);

    pause_state_t              state_q, state_d;
    logic                      btn_q, osd_q;
    logic                      toggle_q, toggle_d;
    logic [SETTLE_W-1:0]       settle_q, settle_d;
    logic [NUM_REQ-1:0]        ack_q, ack_d;
    logic                      dimmed_q, dimmed_d;
    logic [RW+GW+BW-1:0]       rgb_q, rgb_d;
    logic                      btn_rise, want, vb_rise, timer_clr, sec_reached;
    logic                      settled;

`ifdef PAUSE_FRAME_ALIGN_EN
    logic vblank_q;
    always_ff @(posedge clk_sys) begin
        vblank_q <= vblank;
    end
    assign vb_rise = vblank & ~vblank_q;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign vb_rise       = 1'b1;
`endif

    // Edge registers load the live input on reset too, so a held input never looks like an edge.
    always_ff @(posedge clk_sys) begin
        btn_q <= user_button;
        osd_q <= osd_status;
    end

    assign btn_rise = user_button & ~btn_q;
    assign toggle_d = toggle_q ^ btn_rise;
    assign want     = toggle_q | (osd_status & options[0]) | (|pause_req);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (want)    state_d = ENTER;
            ENTER:   if (vb_rise) state_d = PAUSED;
            PAUSED:  if (!want)   state_d = EXIT;
            EXIT: begin
                if (want)         state_d = PAUSED;
                else if (vb_rise) state_d = RUN;
            end
            default:              state_d = RUN;
        endcase
    end

    assign settled = (settle_q == SETTLE_W'(ACK_PAD));

    always_comb begin
        settle_d = settle_q;
        if (state_q == RUN) begin
            settle_d = '0;
        end else if (state_q == PAUSED && !settled) begin
            settle_d = settle_q + 1'b1;
        end
    end

    assign ack_d = pause_req & {NUM_REQ{(state_q == PAUSED) && settled}};

    assign timer_clr = (state_q != PAUSED) | (user_button ^ btn_q) | (osd_status ^ osd_q);

    pause_sec_timer #(
        .CYC  (cycles_per_sec(CLKSPEED)),
        .SECS (DIM_SECONDS)
    ) u_sec_timer (
        .clk_i         (clk_sys),
        .reset_i       (reset),
        .clr_i         (timer_clr),
        .sec_reached_o (sec_reached)
    );

    assign dimmed_d = options[1] & (state_q == PAUSED) & sec_reached;
    // Each channel shifts on its own, so no bit crosses into the neighbouring channel.
    assign rgb_d    = dimmed_q ? {r >> 1, g >> 1, b >> 1} : {r, g, b};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= RUN;
            toggle_q <= 1'b0;
            settle_q <= '0;
            ack_q    <= '0;
            dimmed_q <= 1'b0;
            rgb_q    <= '0;
        end else begin
            state_q  <= state_d;
            toggle_q <= toggle_d;
            settle_q <= settle_d;
            ack_q    <= ack_d;
            dimmed_q <= dimmed_d;
            rgb_q    <= rgb_d;
        end
    end

    assign pause_cpu = (state_q != RUN);
    assign pause_ack = ack_q;
    assign dimmed    = dimmed_q;
    assign rgb_out   = rgb_q;

endmodule

// File: tb/tb_pause_ctrl_multi.sv
`timescale 1ns/1ps
module tb_pause_ctrl_multi;

    localparam int CLKSPEED = 1;
    localparam int DIM_SEC  = 2;
    localparam int NREQ     = 2;
    localparam int ACKPAD   = 4;
    localparam int CYC      = CLKSPEED * 1_000_000;

    logic            clk_sys = 1'b0;
    logic            reset;
    logic            user_button;
    logic            osd_status;
    logic [1:0]      options;
    logic [NREQ-1:0] pause_req;
    logic [NREQ-1:0] pause_ack;
    logic            vblank;
    logic [2:0]      r, g, b;
    logic [8:0]      rgb_out;
    logic            pause_cpu;
    logic            dimmed;

    int tests = 0;
    int fails = 0;

    pause_ctrl_multi #(
        .RW(3), .GW(3), .BW(3),
        .CLKSPEED(CLKSPEED), .DIM_SECONDS(DIM_SEC),
        .NUM_REQ(NREQ), .ACK_PAD(ACKPAD)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .user_button (user_button),
        .osd_status  (osd_status),
        .options     (options),
        .pause_req   (pause_req),
        .pause_ack   (pause_ack),
        .vblank      (vblank),
        .r           (r),
        .g           (g),
        .b           (b),
        .rgb_out     (rgb_out),
        .pause_cpu   (pause_cpu),
        .dimmed      (dimmed)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; user_button = 1'b0; osd_status = 1'b0; options = 2'b00;
        pause_req = '0; vblank = 1'b0; r = 3'b101; g = 3'b000; b = 3'b000;
        tick(2);
        check("rst_pause_cpu", pause_cpu, 0);
        check("rst_ack",       pause_ack, 0);
        check("rst_dimmed",    dimmed, 0);
        check("rst_rgb",       rgb_out, 0);

        // T1: reset release, pixel passes through after one cycle
        reset = 1'b0;
        tick(1);
        check("t1_rgb",       rgb_out, 9'b101_000_000);
        check("t1_pause_cpu", pause_cpu, 0);

`ifndef PAUSE_FRAME_ALIGN_EN
        // T2: button press -> pause_cpu two edges later; second press -> falls 3 edges after press
        user_button = 1'b1;
        tick(1);
        check("t2_cpu_c1", pause_cpu, 0);
        tick(1);
        check("t2_cpu_c2", pause_cpu, 1);
        user_button = 1'b0;
        tick(2);
        user_button = 1'b1;
        tick(2);
        check("t2_exit_hold", pause_cpu, 1);
        tick(1);
        check("t2_exit_done", pause_cpu, 0);
        user_button = 1'b0;
        tick(2);

        // T3: ENTER after 1 edge, PAUSED after 2, ack once settle saturates: ACKPAD+3 edges after request
        pause_req = 2'b10;
        tick(1);
        check("t3_cpu", pause_cpu, 1);
        tick(ACKPAD + 1);
        check("t3_ack_early", pause_ack, 2'b00);
        tick(1);
        check("t3_ack", pause_ack, 2'b10);
        pause_req = 2'b11;
        tick(1);
        check("t3_ack_both", pause_ack, 2'b11);
        pause_req = 2'b10;
        tick(1);
        check("t3_ack_drop0", pause_ack, 2'b10);
        pause_req = 2'b00;
        tick(1);
        check("t3_ack_drop", pause_ack, 2'b00);
        check("t3_cpu_exit", pause_cpu, 1);
        tick(1);
        check("t3_cpu_run", pause_cpu, 0);
        tick(2);

        // T4: dim after DIM_SEC seconds of PAUSED (PAUSED begins after the 3rd edge)
        options = 2'b10; r = 3'b111; g = 3'b100; b = 3'b001;
        user_button = 1'b1;
        tick(3 + DIM_SEC * CYC);
        check("t4_dim_early", dimmed, 0);
        tick(1);
        check("t4_dim", dimmed, 1);
        check("t4_rgb_pre", rgb_out, 9'b111_100_001);
        tick(1);
        check("t4_rgb_dim", rgb_out, 9'b011_010_000);
        // button release is an edge: restarts the count without toggling
        user_button = 1'b0;
        tick(1);
        check("t4_dim_hold", dimmed, 1);
        tick(1);
        check("t4_dim_clr", dimmed, 0);
        tick(1000);
        check("t4_dim_restart", dimmed, 0);
        check("t4_rgb_plain", rgb_out, 9'b111_100_001);
        check("t4_cpu", pause_cpu, 1);
        options = 2'b00;
        user_button = 1'b1;
        tick(3);
        check("t4_unpause", pause_cpu, 0);
        user_button = 1'b0;
        tick(2);

        // T5: OSD pauses only with options[0]
        osd_status = 1'b1;
        tick(2);
        check("t5_osd_nopause", pause_cpu, 0);
        options = 2'b01;
        tick(1);
        check("t5_osd_pause", pause_cpu, 1);
        user_button = 1'b1;
        tick(1);
        user_button = 1'b0; osd_status = 1'b0;
        tick(3);
        check("t5_toggle_holds", pause_cpu, 1);
        user_button = 1'b1;
        tick(3);
        check("t5_release", pause_cpu, 0);
        user_button = 1'b0; options = 2'b00;
        tick(2);

        // Simultaneous toggle edge and request drop: new want stays high
        pause_req = 2'b01;
        tick(ACKPAD + 3);
        check("sim_ack", pause_ack, 2'b01);
        user_button = 1'b1; pause_req = 2'b00;
        tick(3);
        check("sim_cpu", pause_cpu, 1);
        check("sim_ack_drop", pause_ack, 2'b00);
        user_button = 1'b0;
        tick(1);
        user_button = 1'b1;
        tick(3);
        check("sim_release", pause_cpu, 0);
        user_button = 1'b0;
        tick(2);
`else
        // T6: frame aligned pause: CPU stops at once, PAUSED waits for vblank rise
        pause_req = 2'b10;
        tick(1);
        check("t6_cpu", pause_cpu, 1);
        tick(20);
        check("t6_ack_wait", pause_ack, 2'b00);
        check("t6_cpu_hold", pause_cpu, 1);
        vblank = 1'b1;
        tick(1);
        vblank = 1'b0;
        tick(ACKPAD);
        check("t6_ack_early", pause_ack, 2'b00);
        tick(1);
        check("t6_ack", pause_ack, 2'b10);
        pause_req = 2'b00;
        tick(1);
        check("t6_ack_drop", pause_ack, 2'b00);
        tick(10);
        check("t6_exit_hold", pause_cpu, 1);
        vblank = 1'b1;
        tick(1);
        check("t6_exit_done", pause_cpu, 0);
        vblank = 1'b0;
        tick(2);
`endif

        // Reset asserted while in ENTER
        pause_req = 2'b01;
        tick(1);
        check("rst_enter_cpu", pause_cpu, 1);
        reset = 1'b1;
        tick(1);
        check("rst_mid_cpu", pause_cpu, 0);
        check("rst_mid_ack", pause_ack, 2'b00);
        check("rst_mid_dim", dimmed, 0);
        check("rst_mid_rgb", rgb_out, 0);
        reset = 1'b0; pause_req = 2'b00;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
